// File: rtl/regfile_controller.sv
// Multicycle initiator for an 8x16 register file: accepts one instruction per s/w
// handshake, reads operands, runs shift+ALU in local registers, writes back, keeps Z/N/V.
module regfile_controller #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RSEL  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic [WIDTH-1:0] in,
  output logic             w,
  output logic [RSEL-1:0]  readnum,
  input  logic [WIDTH-1:0] rf_out,
  output logic [RSEL-1:0]  writenum,
  output logic             write,
  output logic [WIDTH-1:0] data_in,
  output logic [2:0]       status
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG
  } state_e;

  typedef enum logic [2:0] {
    K_NOP, K_MOVI, K_MOVR, K_ADD, K_CMP, K_AND, K_MVN
  } kind_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_ir, r_a, r_b, r_c;
  logic [WIDTH-1:0] w_ir_nxt, w_a_nxt, w_b_nxt, w_c_nxt;
  logic [2:0]       r_status, w_status_nxt;

  logic             r_w, r_write, w_w_nxt, w_write_nxt;
  logic [RSEL-1:0]  r_readnum, r_writenum, w_readnum_nxt, w_writenum_nxt;
  logic [WIDTH-1:0] r_data_in, w_data_nxt;

  kind_e            w_kind;
  logic [WIDTH-1:0] w_shb, w_sub, w_result, w_imm;
  logic             w_ovf;

  always_comb begin
    w_kind = K_NOP;
    case ({r_ir[15:13], r_ir[12:11]})
      5'b110_10: w_kind = K_MOVI;
      5'b110_00: w_kind = K_MOVR;
      5'b101_00: w_kind = K_ADD;
      5'b101_01: w_kind = K_CMP;
      5'b101_10: w_kind = K_AND;
      5'b101_11: w_kind = K_MVN;
      default:   w_kind = K_NOP;
    endcase
  end

  always_comb begin
    case (r_ir[4:3])
      2'b01:   w_shb = {r_b[WIDTH-2:0], 1'b0};
      2'b10:   w_shb = {1'b0, r_b[WIDTH-1:1]};
      2'b11:   w_shb = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
      default: w_shb = r_b;
    endcase
  end

  assign w_sub = r_a - w_shb;
  assign w_ovf = (r_a[WIDTH-1] ^ w_shb[WIDTH-1]) & (w_sub[WIDTH-1] ^ r_a[WIDTH-1]);
  assign w_imm = {{(WIDTH-8){r_ir[7]}}, r_ir[7:0]};

  // MOV reg shares the adder path: A is cleared in DECODE so A+shB == shB.
  always_comb begin
    case (w_kind)
      K_AND:   w_result = r_a & w_shb;
      K_MVN:   w_result = ~w_shb;
      K_CMP:   w_result = w_sub;
      default: w_result = r_a + w_shb;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ir_nxt     = r_ir;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_c_nxt      = r_c;
    w_status_nxt = r_status;
    case (r_state)
      S_WAIT: begin
        if (s) begin
          w_ir_nxt    = in;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_kind)
          K_MOVI:              w_state_nxt = S_WRITE_IMM;
          K_MOVR, K_MVN: begin
            w_a_nxt     = '0;
            w_state_nxt = S_GET_B;
          end
          K_ADD, K_CMP, K_AND: w_state_nxt = S_GET_A;
          default:             w_state_nxt = S_WAIT;
        endcase
      end
      S_GET_A: begin
        w_a_nxt     = rf_out;
        w_state_nxt = S_GET_B;
      end
      S_GET_B: begin
        w_b_nxt     = rf_out;
        w_state_nxt = S_ALU;
      end
      S_ALU: begin
        w_c_nxt = w_result;
        if (w_kind == K_CMP) begin
          w_status_nxt = {(w_sub == '0), w_sub[WIDTH-1], w_ovf};
          w_state_nxt  = S_WAIT;
        end else begin
          w_state_nxt = S_WRITE_REG;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // Outputs are registered by decoding the state being entered, so the
  // register file sees readnum/write in the same cycle the FSM occupies that state.
  always_comb begin
    w_w_nxt        = (w_state_nxt == S_WAIT);
    w_readnum_nxt  = '0;
    w_writenum_nxt = '0;
    w_write_nxt    = 1'b0;
    w_data_nxt     = w_c_nxt;
    case (w_state_nxt)
      S_GET_A: w_readnum_nxt = r_ir[10:8];
      S_GET_B: w_readnum_nxt = r_ir[2:0];
      S_WRITE_IMM: begin
        w_writenum_nxt = r_ir[10:8];
        w_write_nxt    = 1'b1;
        w_data_nxt     = w_imm;
      end
      S_WRITE_REG: begin
        w_writenum_nxt = r_ir[7:5];
        w_write_nxt    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_WAIT;
      r_ir       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_status   <= '0;
      r_w        <= 1'b1;
      r_readnum  <= '0;
      r_writenum <= '0;
      r_write    <= 1'b0;
      r_data_in  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ir       <= w_ir_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_c        <= w_c_nxt;
      r_status   <= w_status_nxt;
      r_w        <= w_w_nxt;
      r_readnum  <= w_readnum_nxt;
      r_writenum <= w_writenum_nxt;
      r_write    <= w_write_nxt;
      r_data_in  <= w_data_nxt;
    end
  end

  assign w        = r_w;
  assign readnum  = r_readnum;
  assign writenum = r_writenum;
  assign write    = r_write & ~reset;
  assign data_in  = r_data_in;
  assign status   = r_status;

endmodule

// File: tb/tb_regfile_controller.sv
// Bench for regfile_controller: an 8x16 register file model plus an ISA-level
// reference that predicts each write (scoreboard), latency, and status flags.
module tb_regfile_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s = 1'b0;
  logic [15:0] in = '0;
  logic        w;
  logic [2:0]  readnum, writenum;
  logic [15:0] rf_out, data_in;
  logic        write;
  logic [2:0]  status;

  int vectors = 0;
  int miscompares = 0;

  regfile_controller #(.WIDTH(16), .RSEL(3)) dut (
    .clk(clk), .reset(reset), .s(s), .in(in), .w(w),
    .readnum(readnum), .rf_out(rf_out), .writenum(writenum),
    .write(write), .data_in(data_in), .status(status)
  );

  always #5 clk = ~clk;

  logic [15:0] rf [8];
  assign rf_out = rf[readnum];
  always @(posedge clk) if (write) rf[writenum] <= data_in;

  logic [15:0] m_rf [8];
  logic [2:0]  m_status = 3'b000;
  logic [18:0] exp_q [$];
  logic [2:0]  rd_trace [$];

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf[i]   = '0;
      m_rf[i] = '0;
    end
  end

  // Scoreboard: every observed write pulse must match the oldest predicted write.
  always @(negedge clk) begin
    if (write === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wr_unexpected: got writenum=%0d data_in=%h, expected no write", writenum, data_in);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({writenum, data_in} !== e) begin
          miscompares++;
          $display("FAIL wr_data: got writenum=%0d data_in=%h, expected writenum=%0d data_in=%h",
                   writenum, data_in, e[18:16], e[15:0]);
        end
      end
    end
  end

  function automatic logic [15:0] ref_shift(input logic [15:0] v, input logic [1:0] sc);
    logic signed [15:0] sv;
    sv = v;
    case (sc)
      2'd1:    return v << 1;
      2'd2:    return v >> 1;
      2'd3:    return 16'(sv >>> 1);
      default: return v;
    endcase
  endfunction

  function automatic void model(input logic [15:0] ins, output bit wr, output logic [2:0] wn,
                                output logic [15:0] wd, output int lat);
    logic [15:0] a, b, r;
    a   = m_rf[ins[10:8]];
    b   = ref_shift(m_rf[ins[2:0]], ins[4:3]);
    wr  = 1'b1;
    wn  = ins[7:5];
    wd  = '0;
    lat = 2;
    if (ins[15:13] == 3'b110 && ins[12:11] == 2'b10) begin
      wn = ins[10:8]; wd = {{8{ins[7]}}, ins[7:0]}; lat = 3;
    end else if (ins[15:13] == 3'b110 && ins[12:11] == 2'b00) begin
      wd = b; lat = 5;
    end else if (ins[15:13] == 3'b101) begin
      case (ins[12:11])
        2'b00: begin wd = a + b; lat = 6; end
        2'b01: begin
          r  = a - b;
          wr = 1'b0;
          lat = 5;
          m_status = {r == 16'h0, r[15], (a[15] != b[15]) && (r[15] != a[15])};
        end
        2'b10: begin wd = a & b; lat = 6; end
        default: begin wd = ~b; lat = 5; end
      endcase
    end else begin
      wr = 1'b0;
    end
    if (wr) m_rf[wn] = wd;
  endfunction

  task automatic exec(input logic [15:0] instr, input bit noisy, output int lat, output int elat);
    bit wr;
    logic [2:0] wn;
    logic [15:0] wd;
    model(instr, wr, wn, wd, elat);
    if (wr) exp_q.push_back({wn, wd});
    rd_trace.delete();
    @(negedge clk);
    in = instr;
    s  = 1'b1;
    @(posedge clk); #1;
    s   = 1'b0;
    in  = 16'($urandom);
    lat = 1;
    while (w !== 1'b1 && lat < 20) begin
      rd_trace.push_back(readnum);
      if (noisy) begin
        s  = 1'($urandom);
        in = 16'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    s = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (write !== 1'b0) begin miscompares++; $display("FAIL rst_write: got %b, expected 0", write); end
    reset = 1'b0;
    vectors++;
    if ({w, readnum, writenum, data_in, status} !== {1'b1, 3'd0, 3'd0, 16'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL rst_state: got w=%b rd=%0d wn=%0d din=%h st=%b, expected w=1 rd=0 wn=0 din=0000 st=000",
               w, readnum, writenum, data_in, status);
    end
  endtask

  task automatic test_mov_imm();
    int lat, elat;
    logic [15:0] ins [2];
    logic [15:0] want [2];
    ins  = '{16'hD007, 16'hD1FE};
    want = '{16'h0007, 16'hFFFE};
    for (int i = 0; i < 2; i++) begin
      exec(ins[i], 1'b0, lat, elat);
      vectors++;
      if (lat !== 3) begin miscompares++; $display("FAIL movi_lat: got %0d, expected 3", lat); end
      vectors++;
      if (rf[i] !== want[i]) begin miscompares++; $display("FAIL movi_rf%0d: got %h, expected %h", i, rf[i], want[i]); end
    end
  endtask

  task automatic test_add();
    int lat, elat;
    exec(16'hA148, 1'b0, lat, elat);
    vectors++;
    if (lat !== 6) begin miscompares++; $display("FAIL add_lat: got %0d, expected 6", lat); end
    vectors++;
    if (rd_trace.size() < 3 || rd_trace[1] !== 3'd1 || rd_trace[2] !== 3'd0) begin
      miscompares++;
      $display("FAIL add_readnum: got %0d trace entries, expected readnum 1 then 0", rd_trace.size());
    end
    vectors++;
    if (rf[2] !== 16'h000C) begin miscompares++; $display("FAIL add_rf2: got %h, expected 000c", rf[2]); end
    vectors++;
    if (status !== 3'b000) begin miscompares++; $display("FAIL add_status: got %b, expected 000", status); end
  endtask

  task automatic test_shift_mvn();
    int lat, elat;
    logic [15:0] ins [4];
    logic [2:0]  dst [4];
    logic [15:0] want [4];
    // MOV R5,R1,ASR1 / MOV R3,R1,LSR1 / MVN R4,R3 / AND R7,R1,R5,LSR1
    ins  = '{16'hC0B9, 16'hC071, 16'hB883, 16'hB1F5};
    dst  = '{3'd5, 3'd3, 3'd4, 3'd7};
    want = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h7FFE};
    for (int i = 0; i < 4; i++) begin
      exec(ins[i], 1'b0, lat, elat);
      vectors++;
      if (lat !== elat) begin miscompares++; $display("FAIL alu_lat %h: got %0d, expected %0d", ins[i], lat, elat); end
      vectors++;
      if (rf[dst[i]] !== want[i]) begin
        miscompares++; $display("FAIL alu_rf %h: got %h, expected %h", ins[i], rf[dst[i]], want[i]);
      end
    end
  endtask

  task automatic test_cmp();
    int lat, elat;
    logic [15:0] ins [2];
    logic [2:0]  want [2];
    ins  = '{16'hAC00, 16'hA800};
    want = '{3'b001, 3'b100};
    for (int i = 0; i < 2; i++) begin
      exec(ins[i], 1'b0, lat, elat);
      vectors++;
      if (lat !== 5) begin miscompares++; $display("FAIL cmp_lat: got %0d, expected 5", lat); end
      vectors++;
      if (status !== want[i]) begin miscompares++; $display("FAIL cmp_status %h: got %b, expected %b", ins[i], status, want[i]); end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL cmp_pending: got %0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_nop();
    int lat, elat;
    logic [15:0] ins [2];
    // opcode 111 is not a defined instruction and must decode as NOP
    ins = '{16'h0000, 16'hE083};
    for (int i = 0; i < 2; i++) begin
      exec(ins[i], 1'b0, lat, elat);
      vectors++;
      if (lat !== 2) begin miscompares++; $display("FAIL nop_lat %h: got %0d, expected 2", ins[i], lat); end
    end
    vectors++;
    if (status !== m_status) begin miscompares++; $display("FAIL nop_status: got %b, expected %b", status, m_status); end
  endtask

  task automatic test_busy_ignore();
    int lat, elat;
    exec(16'hA2E2, 1'b1, lat, elat);
    vectors++;
    if (lat !== 6) begin miscompares++; $display("FAIL busy_lat: got %0d, expected 6", lat); end
    vectors++;
    if (rf[7] !== 16'h0018) begin miscompares++; $display("FAIL busy_rf7: got %h, expected 0018", rf[7]); end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0 || w !== 1'b1) begin
      miscompares++; $display("FAIL busy_idle: got pending=%0d w=%b, expected pending=0 w=1", exp_q.size(), w);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, el1, el2;
    bit wr;
    logic [2:0] wn;
    logic [15:0] wd;
    model(16'hD355, wr, wn, wd, el1);
    exp_q.push_back({wn, wd});
    model(16'hC0A3, wr, wn, wd, el2);
    exp_q.push_back({wn, wd});
    @(negedge clk);
    in = 16'hD355;
    s  = 1'b1;
    @(posedge clk); #1;
    in   = 16'hC0A3;
    lat1 = 1;
    while (w !== 1'b1 && lat1 < 20) begin @(posedge clk); #1; lat1++; end
    @(posedge clk); #1;
    s = 1'b0;
    vectors++;
    if (w !== 1'b0) begin miscompares++; $display("FAIL b2b_accept: got w=%b, expected 0", w); end
    lat2 = 1;
    while (w !== 1'b1 && lat2 < 20) begin @(posedge clk); #1; lat2++; end
    vectors++;
    if (lat1 !== 3 || lat2 !== 5) begin
      miscompares++; $display("FAIL b2b_lat: got %0d,%0d, expected 3,5", lat1, lat2);
    end
    vectors++;
    if (rf[5] !== 16'h0055) begin miscompares++; $display("FAIL b2b_rf5: got %h, expected 0055", rf[5]); end
  endtask

  task automatic test_reset_in_write();
    @(negedge clk);
    in = 16'hA1C0;
    s  = 1'b1;
    @(posedge clk); #1;
    s = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (write !== 1'b1 || writenum !== 3'd6) begin
      miscompares++; $display("FAIL rw_reach: got write=%b wn=%0d, expected write=1 wn=6", write, writenum);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (write !== 1'b0) begin miscompares++; $display("FAIL rw_gate: got %b, expected 0", write); end
    @(posedge clk); #1;
    reset    = 1'b0;
    m_status = 3'b000;
    vectors++;
    if (w !== 1'b1 || status !== 3'b000) begin
      miscompares++; $display("FAIL rw_after: got w=%b st=%b, expected w=1 st=000", w, status);
    end
    @(posedge clk); #1;
    vectors++;
    if (rf[6] !== m_rf[6]) begin miscompares++; $display("FAIL rw_rf6: got %h, expected %h", rf[6], m_rf[6]); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_shift_mvn();
    test_cmp();
    test_nop();
    test_busy_ignore();
    test_back_to_back();
    test_reset_in_write();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL final_pending: got %0d, expected 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
